uart_rx_fb_loader: RTL
======================

Name: uart_rx_fb_loader

Overview:
- Receive-side counterpart of the camera UART TX path.
- Deserializes an 8N1 UART stream using the shared 16x oversampling b_tick.
- Waits for a sync byte, then assembles RGB565 pixels from byte pairs (high byte first) and writes them sequentially into the frame buffer write port.
- Sits between the board RX pin and the frame buffer, so a PC can load a test image for the plotter pipeline.

Parameters:
- DATA_WIDTH, 8: UART data bits per frame.
- IMG_WIDTH, 176: pixels per line.
- IMG_HEIGHT, 240: lines per frame.
- SAMPLING, 16: b_tick pulses per UART bit.
- FB_ADDR_WIDTH, $clog2(IMG_WIDTH*IMG_HEIGHT): frame buffer address width.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CYCLES, 1_000_000: idle clk cycles allowed between bytes while loading.

Ports:
- clk  input  1: system clock.
- reset  input  1: synchronous, active-high.
- b_tick  input  1: oversampling tick, one clk wide, SAMPLING per bit.
- rx  input  1: asynchronous UART line, idle high.
- fb_we  output  1: frame buffer write strobe, one clk wide.
- fb_wAddr  output  FB_ADDR_WIDTH: write address.
- fb_wData  output  16: RGB565 pixel.
- loading  output  1: high from sync acceptance until frame end or abort.
- frame_done  output  1: one-clk pulse after the last pixel write.
- rx_err  output  1: one-clk pulse on framing error or timeout abort.

Behaviour:
- Reset: all outputs 0; FSMs idle; address counter 0; synchronizer flops set to 1.
- Clock is clk. Reset is reset, synchronous, active-high. Reset mid-frame aborts with no frame_done and no rx_err.

Bit-level receive:
- rx passes through a 2-FF synchronizer.
- RX FSM states: IDLE, START, DATA, STOP.
- IDLE -> START on synchronized rx == 0. The tick counter clears.
- START: on the (SAMPLING/2)th b_tick, resample rx.
  - rx == 0: go to DATA.
  - rx == 1: false start, return to IDLE with no output.
- DATA: sample every SAMPLING b_ticks, LSB first, for DATA_WIDTH bits.
- STOP: sample after SAMPLING b_ticks.
  - Sample 1: rx_done pulse (1 clk) with rx_byte.
  - Sample 0: framing error pulse; the byte is discarded.
  - Either way, return to IDLE.

Loader FSM (states WAIT_SYNC, GET_HI, GET_LO):
- WAIT_SYNC: rx_done with byte == SYNC_BYTE moves to GET_HI, sets loading = 1 and clears the address to 0. Any other byte is ignored. Framing errors here are ignored (no rx_err).
- GET_HI: rx_done latches the byte as the high byte and moves to GET_LO. A byte equal to SYNC_BYTE is treated as ordinary data.
- GET_LO: rx_done triggers a write in the following cycle.
  - fb_we = 1, fb_wData = {hi, lo}, fb_wAddr = current address.
  - Address increments after the write.
  - Latency from the stop-bit sample to fb_we is 1 clk.
  - If this was the last address, IMG_WIDTH*IMG_HEIGHT-1:
    - frame_done pulses in the same cycle as that fb_we.
    - loading drops in the next cycle.
    - Address returns to 0 and the FSM returns to WAIT_SYNC.
  - Otherwise return to GET_HI.
- fb_wAddr holds its value between writes; fb_wData is only meaningful while fb_we is high.

Aborts and boundary conditions:
- Framing error in GET_HI or GET_LO: rx_err pulse, go to WAIT_SYNC, loading = 0, address = 0. A pending high byte is dropped.
- Timeout: a counter runs while loading and clears on every rx_done. Reaching TIMEOUT_CYCLES-1 causes the same abort as a framing error, including the rx_err pulse.
- No backpressure: the frame buffer accepts a write every cycle. Byte spacing is at least 10 bit-times, so rx_done and fb_we never collide.

Decomposition:
- Package uart_pkg:
  - rx_state_e (IDLE, START, DATA, STOP).
  - load_state_e (WAIT_SYNC, GET_HI, GET_LO).
  - Default SYNC_BYTE constant.
  - PIXEL_W = 16.
- Sub-module uart_rx:
  - Contents: synchronizer, oversampling bit FSM.
  - Outputs: rx_done, rx_byte, rx_frame_err.
- The top holds the loader FSM, address counter and timeout counter.

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=2, SAMPLING=16, b_tick every 4 clk, TIMEOUT_CYCLES=2000):
1. Single byte 8'h3C after sync -> no fb_we; loading=1; after a second byte 8'hC3 -> fb_we with addr 0, data 16'h3CC3, exactly 1 clk after the stop sample.
2. Full frame:
   - Stimulus: 8'h00 (ignored), 8'hA5, then 16 bytes 8'h00..8'h0F.
   - Response: 8 writes at addr 0..7, data 16'h0001, 16'h0203, ... 16'h0E0F.
   - frame_done coincides with the addr-7 write; loading falls the next clk.
3. Framing error: stop bit 0 on the 3rd data byte -> rx_err pulse, loading=0, no write for that pixel; a new sync plus 2 bytes writes at addr 0.
4. False start: rx low for 6 b_ticks only -> no rx_done, no rx_err, FSM stays idle; the next valid byte is received correctly.
5. Timeout: sync plus 3 bytes, then line idle -> rx_err 2000 clk after the last rx_done; loading=0; only the addr-0 write occurred.
6. Reset asserted mid-frame after 5 bytes -> all outputs 0; the next sync restarts at addr 0; 8'hA5 sent as pixel data is written as data.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive / frame buffer loader path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    WAIT_SYNC,
    GET_HI,
    GET_LO
  } load_state_e;

  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
  localparam int unsigned PIXEL_W       = 16;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer plus 16x oversampling bit FSM.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SAMPLING   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  b_tick,
  input  logic                  rx,
  output logic                  rx_done,
  output logic [DATA_WIDTH-1:0] rx_byte,
  output logic                  rx_frame_err
);

  localparam int unsigned CNT_W = $clog2(SAMPLING);
  localparam int unsigned BIT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SAMPLING / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(SAMPLING - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  rx_state_e        state;
  logic             sync1;
  logic             rx_s;
  logic [CNT_W-1:0] s_cnt;
  logic [BIT_W-1:0] n;

  // rx_byte doubles as the shift register; it is only meaningful with rx_done.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1        <= 1'b1;
      rx_s         <= 1'b1;
      state        <= IDLE;
      s_cnt        <= '0;
      n            <= '0;
      rx_byte      <= '0;
      rx_done      <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      sync1        <= rx;
      rx_s         <= sync1;
      rx_done      <= 1'b0;
      rx_frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s_cnt <= '0;
          end
        end
        START: begin
          if (b_tick) begin
            if (s_cnt == HALF_LAST) begin
              s_cnt <= '0;
              n     <= '0;
              state <= rx_s ? IDLE : DATA;
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (b_tick) begin
            if (s_cnt == FULL_LAST) begin
              s_cnt   <= '0;
              rx_byte <= {rx_s, rx_byte[DATA_WIDTH-1:1]};
              if (n == BIT_LAST) state <= STOP;
              else               n     <= n + 1'b1;
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (b_tick) begin
            if (s_cnt == FULL_LAST) begin
              state        <= IDLE;
              rx_done      <= rx_s;
              rx_frame_err <= !rx_s;
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fb_loader.sv
// Loads an RGB565 image received over UART (sync byte, then hi/lo byte pairs) into a frame buffer.
module uart_rx_fb_loader
  import uart_pkg::*;
#(
  parameter int unsigned     DATA_WIDTH     = 8,
  parameter int unsigned     IMG_WIDTH      = 176,
  parameter int unsigned     IMG_HEIGHT     = 240,
  parameter int unsigned     SAMPLING       = 16,
  parameter int unsigned     FB_ADDR_WIDTH  = $clog2(IMG_WIDTH * IMG_HEIGHT),
  parameter logic [7:0]      SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int unsigned     TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     b_tick,
  input  logic                     rx,
  output logic                     fb_we,
  output logic [FB_ADDR_WIDTH-1:0] fb_wAddr,
  output logic [PIXEL_W-1:0]       fb_wData,
  output logic                     loading,
  output logic                     frame_done,
  output logic                     rx_err
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0]          TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [FB_ADDR_WIDTH-1:0] PIX_LAST = FB_ADDR_WIDTH'(IMG_WIDTH * IMG_HEIGHT - 1);

  logic                     rx_done;
  logic [DATA_WIDTH-1:0]    rx_byte;
  logic                     rx_frame_err;
  load_state_e              state;
  logic [FB_ADDR_WIDTH-1:0] addr;
  logic [TO_W-1:0]          tcnt;
  logic [DATA_WIDTH-1:0]    hi;
  logic                     active;

  uart_rx #(
    .DATA_WIDTH (DATA_WIDTH),
    .SAMPLING   (SAMPLING)
  ) u_rx (
    .clk          (clk),
    .reset        (reset),
    .b_tick       (b_tick),
    .rx           (rx),
    .rx_done      (rx_done),
    .rx_byte      (rx_byte),
    .rx_frame_err (rx_frame_err)
  );

  assign active = (state != WAIT_SYNC);

  // Loader FSM; aborts (framing error or inter-byte timeout) take priority over byte handling.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WAIT_SYNC;
      addr       <= '0;
      tcnt       <= '0;
      hi         <= '0;
      fb_we      <= 1'b0;
      fb_wAddr   <= '0;
      fb_wData   <= '0;
      loading    <= 1'b0;
      frame_done <= 1'b0;
      rx_err     <= 1'b0;
    end else begin
      fb_we      <= 1'b0;
      frame_done <= 1'b0;
      rx_err     <= 1'b0;
      if (frame_done) loading <= 1'b0;

      if (active && !rx_done) tcnt <= tcnt + 1'b1;
      else                    tcnt <= '0;

      if (active && (rx_frame_err || tcnt == TO_LAST)) begin
        rx_err  <= 1'b1;
        state   <= WAIT_SYNC;
        loading <= 1'b0;
        addr    <= '0;
        tcnt    <= '0;
      end else begin
        case (state)
          WAIT_SYNC: begin
            if (rx_done && rx_byte == SYNC_BYTE) begin
              state   <= GET_HI;
              loading <= 1'b1;
              addr    <= '0;
            end
          end
          GET_HI: begin
            if (rx_done) begin
              hi    <= rx_byte;
              state <= GET_LO;
            end
          end
          GET_LO: begin
            if (rx_done) begin
              fb_we    <= 1'b1;
              fb_wData <= PIXEL_W'({hi, rx_byte});
              fb_wAddr <= addr;
              if (addr == PIX_LAST) begin
                frame_done <= 1'b1;
                addr       <= '0;
                state      <= WAIT_SYNC;
              end else begin
                addr  <= addr + 1'b1;
                state <= GET_HI;
              end
            end
          end
          default: state <= WAIT_SYNC;
        endcase
      end
    end
  end

endmodule
